// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access-size encodings,
// controller states and the alignment rule applied when a request is accepted.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RMW_RD,
      ST_WRITE,
      ST_RESP
   } mau_state_t;

   // Size 2'b11 has no legal encoding, so it is reported like a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = offset[0];
         SZ_WORD: is_misaligned = |offset;
         default: is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus the word-memory port of the access unit.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Little-endian byte-lane logic: sub-word load extraction/extension and
// store-data merge into an existing memory word.
module byte_lane_unit
   import mem_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_old_word,
   input  logic [31:0] i_new_data,
   output logic [31:0] o_load_val,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_old_word[{i_offset, 3'b000} +: 8];
   assign w_half = i_old_word[{i_offset[1], 4'b0000} +: 16];

   always_comb begin
      o_load_val = 32'd0;
      case (i_size)
         SZ_BYTE: o_load_val = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         SZ_HALF: o_load_val = {{16{w_half[15] & ~i_unsigned}}, w_half};
         SZ_WORD: o_load_val = i_old_word;
         default: o_load_val = 32'd0;
      endcase
   end

   // Each lane either keeps the old byte or takes the matching byte of the store data.
   generate
      for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       w_en;
         logic [7:0] w_src;

         assign w_en = (i_size == SZ_WORD)
                    || (i_size == SZ_HALF && i_offset[1] == LANE[1])
                    || (i_size == SZ_BYTE && i_offset == LANE);

         assign w_src = (i_size == SZ_BYTE) ? i_new_data[7:0]
                      : (i_size == SZ_HALF) ? i_new_data[8*(gi%2) +: 8]
                      :                       i_new_data[8*gi +: 8];

         assign o_merged[8*gi +: 8] = w_en ? w_src : i_old_word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory: one request at a time,
// sub-word stores via read-modify-write, misaligned requests answered with an error.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_unit_if.slave   bus
);

   mau_state_t        r_state;
   mau_state_t        w_state_next;

   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_word;

   logic              w_accept;
   logic [ADDR_W-1:0] w_word_addr;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_merged;

   assign w_accept    = bus.req_valid && bus.req_ready;
   assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

   byte_lane_unit u_lanes (
      .i_offset   (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_old_word (r_word),
      .i_new_data (r_wdata),
      .o_load_val (w_load_val),
      .o_merged   (w_merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // r_word holds the loaded word, or the old word that a sub-word store merges into.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_word     <= '0;
      end else begin
         if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_err      <= is_misaligned(bus.req_size, bus.req_addr[1:0]);
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
         end
         if (r_state == ST_LOAD || r_state == ST_RMW_RD) begin
            r_word <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      bus.resp_err   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      case (r_state)
         ST_IDLE: begin
            bus.req_ready = ~rst;
            if (bus.req_valid && !rst) begin
               if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                  w_state_next = ST_RESP;
               end else if (!bus.req_we) begin
                  w_state_next = ST_LOAD;
               end else if (bus.req_size == SZ_WORD) begin
                  w_state_next = ST_WRITE;
               end else begin
                  w_state_next = ST_RMW_RD;
               end
            end
         end
         ST_LOAD: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = w_word_addr;
            w_state_next = ST_RESP;
         end
         ST_RMW_RD: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = w_word_addr;
            w_state_next = ST_WRITE;
         end
         ST_WRITE: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = w_word_addr;
            bus.mem_wdata = (r_size == SZ_WORD) ? r_wdata : w_merged;
            w_state_next  = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = r_err;
            bus.resp_rdata = (r_err || r_we) ? '0 : w_load_val;
            w_state_next   = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: transaction-level memory model predicts every cycle of
// the unit's outputs; directed cases pin literal results, then random traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int K_ERR = 0;
   localparam int K_LD  = 1;
   localparam int K_WST = 2;
   localparam int K_SST = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] dmem    [64];
   logic [31:0] ref_mem [64];

   assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_resp   = 0;
   int n_rd     = 0;
   int n_wr     = 0;

   bit          pending = 1'b0;
   int          p_kind, p_c, p_last, p_idx;
   logic [31:0] p_waddr, p_val, p_wword;
   logic [31:0] last_exp_val;
   logic [31:0] last_rdata;
   logic        last_err;

   bit          pl_go = 1'b0;
   int          pl_idx;
   logic [31:0] pl_val;

   logic        e_ready, e_rv, e_err, e_rd, e_wr;
   logic [31:0] e_rdata, e_addr, e_wdata;
   int          d_cmp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // What the request does to memory and what it returns, from the access rules alone.
   task automatic model_accept();
      int nb, sh, bits;
      logic [31:0] word, lowmask, mask;
      nb      = 1 << bus.req_size;
      bits    = 8 * nb;
      sh      = 8 * int'(bus.req_addr[1:0]);
      p_idx   = int'(bus.req_addr[7:2]);
      p_waddr = {bus.req_addr[31:2], 2'b00};
      word    = ref_mem[p_idx];
      p_c     = cyc + 1;
      pending = 1'b1;
      n_acc++;
      p_val   = 32'd0;
      p_wword = 32'd0;
      if (bus.req_size == 2'b11 || (int'(bus.req_addr[1:0]) % nb) != 0) begin
         p_kind = K_ERR;
         p_last = 0;
      end else begin
         lowmask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
         if (!bus.req_we) begin
            p_val = (word >> sh) & lowmask;
            if (!bus.req_unsigned && p_val[bits-1]) p_val = p_val | ~lowmask;
            p_kind = K_LD;
            p_last = 1;
         end else begin
            mask    = lowmask << sh;
            p_wword = (word & ~mask) | ((bus.req_wdata << sh) & mask);
            p_kind  = (nb == 4) ? K_WST : K_SST;
            p_last  = (nb == 4) ? 1 : 2;
         end
      end
      last_exp_val = p_val;
   endtask

   task automatic model_step();
      bit was_ready;
      int d;
      if (rst) begin
         pending = 1'b0;
      end else begin
         was_ready = !pending;
         if (pending) begin
            d = cyc - p_c;
            if ((p_kind == K_WST && d == 0) || (p_kind == K_SST && d == 1))
               ref_mem[p_idx] = p_wword;
            if (d == p_last) pending = 1'b0;
         end
         if (was_ready && bus.req_valid) model_accept();
      end
      cyc++;
   endtask

   // Model on the rising edge; the memory itself commits writes on the falling edge.
   initial begin
      logic [31:0] v;
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         dmem[i]    = v;
         ref_mem[i] = v;
      end
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (pl_go) begin
            dmem[pl_idx]    = pl_val;
            ref_mem[pl_idx] = pl_val;
         end
         if (bus.mem_write) dmem[bus.mem_addr[7:2]] = bus.mem_wdata;
      end
   end

   // Compare process: every cycle, every output against the model's schedule.
   initial forever begin
      @(negedge clk);
      e_ready = !rst && !pending;
      e_rv = 1'b0; e_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_rdata = 32'd0; e_addr = 32'd0; e_wdata = 32'd0;
      if (!rst && pending) begin
         d_cmp = cyc - p_c;
         case (p_kind)
            K_ERR: if (d_cmp == 0) begin e_rv = 1'b1; e_err = 1'b1; end
            K_LD: begin
               if (d_cmp == 0) begin e_rd = 1'b1; e_addr = p_waddr; end
               else if (d_cmp == 1) begin e_rv = 1'b1; e_rdata = p_val; end
            end
            K_WST: begin
               if (d_cmp == 0) begin e_wr = 1'b1; e_addr = p_waddr; e_wdata = p_wword; end
               else if (d_cmp == 1) e_rv = 1'b1;
            end
            default: begin
               if (d_cmp == 0) begin e_rd = 1'b1; e_addr = p_waddr; end
               else if (d_cmp == 1) begin e_wr = 1'b1; e_addr = p_waddr; e_wdata = p_wword; end
               else if (d_cmp == 2) e_rv = 1'b1;
            end
         endcase
      end
      chk("ctrl{rdy,rv,err,rd,wr}",
          32'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write}),
          32'({e_ready, e_rv, e_err, e_rd, e_wr}));
      chk("resp_rdata", bus.resp_rdata, e_rdata);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) n_wr++;
      if (bus.resp_valid) begin
         n_resp++;
         last_rdata = bus.resp_rdata;
         last_err   = bus.resp_err;
         $display("resp cycle %0d rdata=%h err=%0d", cyc, bus.resp_rdata, bus.resp_err);
      end
   end

   // Callers sit just after a rising edge; returns just after the accepting edge.
   task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
      int start;
      bit ok;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      start = n_acc;
      ok    = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (n_acc != start) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
      if (!keep) bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (!pending) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) chk("done_timeout", 32'(ok), 32'd1);
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      pl_idx = int'(addr[7:2]);
      pl_val = val;
      pl_go  = 1'b1;
      @(posedge clk);
      #1;
      pl_go  = 1'b0;
   endtask

   task automatic load_lit(input string name, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] exp);
      do_req(1'b0, size, uns, addr, 32'd0, 1'b0);
      wait_done();
      chk(name, last_rdata, exp);
      chk({name, "_model"}, last_exp_val, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, w0, q0;
      bit keep;
      rst              = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = SZ_WORD;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h10;
      bus.req_wdata    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1'b0);
      wait_done();

      // Word store then load
      do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
      wait_done();
      load_lit("lw_after_sw", SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
      chk("lw_after_sw_err", 32'(last_err), 32'd0);

      // Sub-word load extension
      preload(32'h20, 32'h80FF7F01);
      load_lit("lb_0x23", SZ_BYTE, 1'b0, 32'h23, 32'hFFFFFF80);
      load_lit("lbu_0x23", SZ_BYTE, 1'b1, 32'h23, 32'h00000080);
      load_lit("lh_0x22", SZ_HALF, 1'b0, 32'h22, 32'hFFFF80FF);
      load_lit("lb_0x20", SZ_BYTE, 1'b0, 32'h20, 32'h00000001);

      // Read-modify-write byte store
      preload(32'h30, 32'h11223344);
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h000000AA, 1'b0);
      wait_done();
      chk("sb_mem_word", dmem[12], 32'h1122AA44);
      load_lit("lw_after_sb", SZ_WORD, 1'b0, 32'h30, 32'h1122AA44);

      // Misaligned and illegal requests
      preload(32'h40, 32'h55667788);
      r0 = n_rd;
      w0 = n_wr;
      do_req(1'b0, SZ_WORD, 1'b0, 32'h42, 32'd0, 1'b0);
      wait_done();
      chk("lw_0x42_err", 32'(last_err), 32'd1);
      chk("lw_0x42_rdata", last_rdata, 32'd0);
      do_req(1'b1, SZ_HALF, 1'b0, 32'h41, 32'h00001234, 1'b0);
      wait_done();
      chk("sh_0x41_err", 32'(last_err), 32'd1);
      do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 1'b0);
      wait_done();
      chk("size11_err", 32'(last_err), 32'd1);
      chk("size11_rdata", last_rdata, 32'd0);
      chk("misalign_no_read", 32'(n_rd - r0), 32'd0);
      chk("misalign_no_write", 32'(n_wr - w0), 32'd0);
      chk("misalign_mem", dmem[16], 32'h55667788);

      // Reset during the RMW read cycle
      preload(32'h50, 32'h12345678);
      q0 = n_resp;
      w0 = n_wr;
      do_req(1'b1, SZ_HALF, 1'b0, 32'h50, 32'h0000BEEF, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
      chk("rst_no_write", 32'(n_wr - w0), 32'd0);
      chk("rst_no_resp", 32'(n_resp - q0), 32'd0);
      chk("rst_mem_kept", dmem[20], 32'h12345678);
      @(posedge clk);
      #1;

      // Three queued requests under a held req_valid
      q0 = n_resp;
      do_req(1'b1, SZ_WORD, 1'b0, 32'h60, 32'hCAFEF00D, 1'b1);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h60, 32'd0, 1'b1);
      do_req(1'b0, SZ_BYTE, 1'b1, 32'h61, 32'd0, 1'b0);
      wait_done();
      chk("queue_resp_count", 32'(n_resp - q0), 32'd3);
      chk("queue_last_rdata", last_rdata, 32'h000000F0);

      // Random traffic with occasional resets
      for (int i = 0; i < 300; i++) begin
         keep = (i != 299) && ($urandom_range(0, 3) == 0);
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom, keep);
         if (!keep) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            if ($urandom_range(0, 24) == 0) begin
               rst = 1'b1;
               @(posedge clk);
               #1;
               rst = 1'b0;
            end
         end
      end
      wait_done();
      @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++) chk($sformatf("final_mem[%0d]", i), dmem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline-side initiator for the word-addressed `data_memory`, placed between the EX/MEM pipeline register and the memory's `mem_read`/`mem_write`/`addr`/`write_data`/`read_data` port.
- Accepts one load or store request at a time from the pipeline and handles byte, halfword and word accesses.
- Sub-word stores are done as a read-modify-write on the word memory.
- Holds `req_ready` low while busy, so the pipeline stalls; flags misaligned accesses instead of issuing them.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width (matches `data_memory` `addr`).
- `DATA_W`, 32, data width; fixed at 32, and byte lanes assume 4 bytes per word.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock shared with `data_memory`.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; 1 only in IDLE with `rst` low.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- `req_unsigned` in 1: zero-extend sub-word loads (lbu/lhu); otherwise sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits for sub-word sizes.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned/illegal; valid with `resp_valid`.
- `mem_read` out 1: to `data_memory.mem_read`.
- `mem_write` out 1: to `data_memory.mem_write`.
- `mem_addr` out 32: word-aligned byte address, bits [1:0] = 00.
- `mem_wdata` out 32: to `data_memory.write_data`.
- `mem_rdata` in 32: from `data_memory.read_data`; combinational in the same cycle.

## Operation
State machine states: IDLE, LOAD, RMW_RD, WRITE, RESP.

In IDLE, when `req_valid` and `req_ready` are both 1, the unit latches the request.

Alignment is checked on accept:
- Half requires `addr[0] = 0`.
- Word requires `addr[1:0] = 00`.
- Size 11 is always an error.
- Error path: go to RESP with `resp_err` = 1, `resp_rdata` = 0. No memory strobe is asserted.

Next state on accept:
- Load → LOAD.
- Word store → WRITE.
- Byte/half store → RMW_RD.

LOAD:
- Drive `mem_read` = 1 and `mem_addr = {addr[31:2], 2'b00}`.
- Capture `mem_rdata` at the clock edge and go to RESP.
- Extract data little-endian: byte k = bits [8k+7:8k], halfword at `addr[1]`. Then zero- or sign-extend.

RMW_RD:
- Drive `mem_read` = 1 and capture the old word.
- Merge `req_wdata` into the lanes selected by `addr[1:0]`/size.
- Go to WRITE.

WRITE:
- Drive `mem_write` = 1 with `mem_wdata` = the full word (word store) or the merged word (sub-word store).
- Go to RESP.

RESP:
- `resp_valid` = 1 for exactly one cycle, then IDLE.

General rules:
- `mem_read` and `mem_write` are never both 1.
- Both strobes are 0 in IDLE and RESP.
- `mem_addr` and `mem_wdata` are 0 when no strobe is active.

## Timing
Request accepted at edge T (the sampling edge):
- Load: `mem_read` high during cycle T+1; `resp_valid` high in T+2.
- Word store: `mem_write` high in T+1 (memory writes at the end of T+1); `resp_valid` high in T+2.
- Sub-word store: RMW_RD in T+1, WRITE in T+2, `resp_valid` in T+3.
- Error: `resp_valid` high in T+1.

Throughput:
- `req_ready` is 0 from T+1 until the cycle after RESP.
- Back-to-back requests are therefore spaced 3, 3, 4 or 2 cycles apart.

Reset:
- All outputs are 0 while `rst` = 1, including `req_ready`. State goes to IDLE.
- Reset asserted mid-RMW, after RMW_RD but before WRITE: memory is left unmodified, and no response is produced.
- Requests held during reset are not accepted; they are accepted on the first edge after `rst` falls.

Back-to-back load after store: the memory write completes before the next request can issue a read, so the load returns the new data. No forwarding is needed.

## Structure
- Package `mem_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the state enum `mau_state_t`;
  - `WORD_BYTES` = 4.
- One combinational sub-module, `byte_lane_unit`, covers load extraction/extension and store merging: inputs offset, size, unsigned flag, old word, new data; outputs load value and merged word.
- The FSM and registers stay in `mem_access_unit`.

## Test plan
- Word store then load: `sw 0xDEADBEEF` @ 0x10, then `lw` @ 0x10 → `mem_write` in T+1 with `mem_addr` 0x10, `resp_valid` in T+2; load returns 0xDEADBEEF with `resp_err` 0.
- Byte load extension: word @ 0x20 = 0x80FF7F01.
  - `lb` @ 0x23 → 0xFFFFFF80.
  - `lbu` @ 0x23 → 0x00000080.
  - `lh` @ 0x22 → 0xFFFF80FF.
  - `lb` @ 0x20 → 0x00000001.
- RMW byte store: word @ 0x30 = 0x11223344; `sb 0xAA` @ 0x31 → `mem_read` in T+1, `mem_write` in T+2 with 0x1122AA44, `resp_valid` in T+3; a following `lw` returns 0x1122AA44.
- Misalignment: `lw` @ 0x42, `sh` @ 0x41, size 11 @ 0x40 → each gives `resp_valid` at T+1 with `resp_err` 1 and `resp_rdata` 0; no `mem_read`/`mem_write` pulse; memory is unchanged.
- Reset mid-RMW: `sh 0xBEEF` @ 0x50 (old value 0x12345678); assert `rst` during the RMW_RD cycle → no `mem_write`, no `resp_valid`, memory still 0x12345678; `req_ready` rises after `rst` is released.
- Stall handshake: hold `req_valid` high with three queued requests → each is accepted only when `req_ready` = 1; `resp_valid` count equals 3, and responses come back in order.
